// File: rtl/alu_sequencer.sv
// alu_sequencer: four-op calculator FSM with saturating-to-error range check;
// the multi-cycle restoring divider exists only when CALC_DIV_EN is defined.
module alu_sequencer #(
  parameter int BITS    = 15,
  parameter int MAX_VAL = 9999
) (
  input  logic            clk,
  input  logic            reset_in,
  input  logic            start,
  input  logic [1:0]      op_code,
  input  logic [BITS-1:0] lhs,
  input  logic [BITS-1:0] rhs,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] result,
  output logic            neg,
  output logic [1:0]      err
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXEC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd3;
  localparam logic [1:0] SUMA   = 2'd0;
  localparam logic [1:0] RESTA  = 2'd1;
  localparam logic [1:0] MULT   = 2'd2;
  localparam logic [1:0] DIV    = 2'd3;
  localparam logic [2*BITS-1:0] MAX_W = (2*BITS)'(MAX_VAL);
  logic [1:0]      state_q, state_d, op_q, op_d, err_q, err_d;
  logic [BITS-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic            neg_q, neg_d;
  logic [BITS:0]   sum;
  logic [2*BITS-1:0] sum_w, prod_w;
  logic [BITS-1:0] ex_res;
  logic            ex_neg;
  logic [1:0]      ex_err;
`ifdef CALC_DIV_EN
  localparam logic [1:0] DIVIDE = 2'd2;
  localparam int CW = $clog2(BITS + 1);
  logic [BITS-1:0] quo_q, quo_d, rem_q, rem_d, quo_nx, rem_nx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS:0]   shifted;
  logic            ge, ex_div;
  always_comb begin
    shifted = {rem_q, quo_q[BITS-1]};
    ge      = shifted >= {1'b0, b_q};
    rem_nx  = ge ? BITS'(shifted - {1'b0, b_q}) : shifted[BITS-1:0];
    quo_nx  = {quo_q[BITS-2:0], ge};
  end
`endif
  // Single-cycle outcome of the captured operation, consumed in EXEC
  always_comb begin
    sum    = {1'b0, a_q} + {1'b0, b_q};
    sum_w  = {{(BITS-1){1'b0}}, sum};
    prod_w = {{BITS{1'b0}}, a_q} * {{BITS{1'b0}}, b_q};
    ex_res = '0;
    ex_neg = 1'b0;
    ex_err = 2'b00;
`ifdef CALC_DIV_EN
    ex_div = 1'b0;
`endif
    case (op_q)
      SUMA: begin
        ex_err = sum_w > MAX_W ? 2'b01 : 2'b00;
        ex_res = sum_w > MAX_W ? '0 : sum[BITS-1:0];
      end
      RESTA: begin
        ex_neg = a_q < b_q;
        ex_res = ex_neg ? b_q - a_q : a_q - b_q;
      end
      MULT: begin
        ex_err = prod_w > MAX_W ? 2'b01 : 2'b00;
        ex_res = prod_w > MAX_W ? '0 : prod_w[BITS-1:0];
      end
      DIV: begin
`ifdef CALC_DIV_EN
        ex_err = b_q == '0 ? 2'b10 : 2'b00;
        ex_div = b_q != '0;
`else
        ex_err = 2'b11;
`endif
      end
    endcase
  end
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    neg_d    = neg_q;
    err_d    = err_q;
`ifdef CALC_DIV_EN
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
`endif
    if (abort) begin
      state_d  = IDLE;
      result_d = '0;
      neg_d    = 1'b0;
      err_d    = 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = start ? EXEC : IDLE;
          op_d    = start ? op_code : op_q;
          a_d     = start ? lhs : a_q;
          b_d     = start ? rhs : b_q;
        end
        EXEC: begin
`ifdef CALC_DIV_EN
          if (ex_div) begin
            state_d = DIVIDE;
            quo_d   = a_q;
            rem_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d  = FINISH;
            result_d = ex_res;
            neg_d    = ex_neg;
            err_d    = ex_err;
          end
`else
          state_d  = FINISH;
          result_d = ex_res;
          neg_d    = ex_neg;
          err_d    = ex_err;
`endif
        end
`ifdef CALC_DIV_EN
        DIVIDE: begin
          quo_d    = quo_nx;
          rem_d    = rem_nx;
          cnt_d    = cnt_q + CW'(1);
          state_d  = cnt_q == CW'(BITS - 1) ? FINISH : DIVIDE;
          result_d = cnt_q == CW'(BITS - 1) ? quo_nx : result_q;
          neg_d    = cnt_q == CW'(BITS - 1) ? 1'b0 : neg_q;
          err_d    = cnt_q == CW'(BITS - 1) ? 2'b00 : err_q;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 2'b00;
`ifdef CALC_DIV_EN
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
`ifdef CALC_DIV_EN
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
`endif
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = state_q == FINISH;
  assign result = result_q;
  assign neg    = neg_q;
  assign err    = err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector table plus hand sequences for abort, reset
// and (when CALC_DIV_EN is defined) the multi-cycle divider.
module tb_alu_sequencer;
  localparam int BITS = 15;
  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic start = 1'b0;
  logic [1:0] op_code = 2'd0;
  logic [BITS-1:0] lhs = '0;
  logic [BITS-1:0] rhs = '0;
  logic abort = 1'b0;
  logic busy, done, neg;
  logic [BITS-1:0] result;
  logic [1:0] err;
  int n_chk = 0;
  int n_fail = 0;

  alu_sequencer #(.BITS(BITS), .MAX_VAL(9999)) dut (
    .clk(clk), .reset_in(reset_in), .start(start), .op_code(op_code),
    .lhs(lhs), .rhs(rhs), .abort(abort), .busy(busy), .done(done),
    .result(result), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int l;
    int r;
    int res;
    int ng;
    int er;
    int lat;
    string nm;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    start = 1'b1;
    op_code = v.op;
    lhs = BITS'(v.l);
    rhs = BITS'(v.r);
    tick();
    start = 1'b0;
    lhs = BITS'($urandom);
    rhs = BITS'($urandom);
    chk({v.nm, "_busy"}, int'(busy), 1);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 40);
    chk({v.nm, "_lat"}, lat, v.lat);
    chk({v.nm, "_res"}, int'(result), v.res);
    chk({v.nm, "_neg"}, int'(neg), v.ng);
    chk({v.nm, "_err"}, int'(err), v.er);
    tick();
    chk({v.nm, "_done_pulse"}, int'(done), 0);
    chk({v.nm, "_idle"}, int'(busy), 0);
  endtask

  task automatic watch_no_done(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) seen++;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    int lat;
    vecs.push_back('{2'd0, 1234, 4321, 5555, 0, 0, 1, "suma_basic"});
    vecs.push_back('{2'd0, 9000, 1000, 0, 0, 1, 1, "suma_ovf"});
    vecs.push_back('{2'd0, 5000, 4999, 9999, 0, 0, 1, "suma_max"});
    vecs.push_back('{2'd0, 32767, 2, 0, 0, 1, 1, "suma_wide"});
    vecs.push_back('{2'd2, 99, 102, 0, 0, 1, 1, "mult_ovf"});
    vecs.push_back('{2'd2, 100, 99, 9900, 0, 0, 1, "mult_ok"});
    vecs.push_back('{2'd2, 32767, 32767, 0, 0, 1, 1, "mult_wide"});
    vecs.push_back('{2'd1, 5, 12, 7, 1, 0, 1, "resta_neg"});
    vecs.push_back('{2'd1, 12, 5, 7, 0, 0, 1, "resta_pos"});
    vecs.push_back('{2'd1, 3, 3, 0, 0, 0, 1, "resta_zero"});
`ifdef CALC_DIV_EN
    vecs.push_back('{2'd3, 10, 2, 5, 0, 0, 16, "div_ok"});
    vecs.push_back('{2'd3, 5, 0, 0, 0, 2, 1, "div_zero"});
`else
    vecs.push_back('{2'd3, 10, 2, 0, 0, 3, 1, "div_off"});
    vecs.push_back('{2'd3, 5, 0, 0, 0, 3, 1, "div_off_zero"});
`endif

    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_neg", int'(neg), 0);
    chk("rst_err", int'(err), 0);
    #2 reset_in = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // start held across an operation with new operands: second request ignored
    start = 1'b1; op_code = 2'd0; lhs = 15'd1; rhs = 15'd2;
    tick();
    op_code = 2'd2; lhs = 15'd3; rhs = 15'd3;
    tick();
    start = 1'b0;
    chk("hold_done", int'(done), 1);
    chk("hold_res", int'(result), 3);
    tick();
    chk("hold_idle", int'(busy), 0);
    tick();
    chk("hold_no_requeue", int'(busy), 0);

    v = '{2'd1, 5, 12, 7, 1, 0, 1, "pre_abort"};
    run_op(v);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_res", int'(result), 0);
    chk("abort_start_neg", int'(neg), 0);
    tick();
    chk("abort_start_busy2", int'(busy), 0);

    start = 1'b1; op_code = 2'd1; lhs = 15'd5; rhs = 15'd12;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_exec_busy", int'(busy), 0);
    chk("abort_exec_done", int'(done), 0);
    chk("abort_exec_res", int'(result), 0);
    chk("abort_exec_neg", int'(neg), 0);

    start = 1'b1; op_code = 2'd0; lhs = 15'd9000; rhs = 15'd1000;
    tick();
    start = 1'b0;
    tick();
    chk("abort_fin_done", int'(done), 1);
    chk("abort_fin_err", int'(err), 1);
    abort = 1'b1;
    #1;
    chk("abort_fin_done_held", int'(done), 1);
    tick();
    abort = 1'b0;
    chk("abort_fin_busy", int'(busy), 0);
    chk("abort_fin_done2", int'(done), 0);
    chk("abort_fin_err2", int'(err), 0);

    v = '{2'd1, 5, 12, 7, 1, 0, 1, "pre_reset"};
    run_op(v);
    start = 1'b1; op_code = 2'd0; lhs = 15'd1; rhs = 15'd1;
    tick();
    start = 1'b0;
    chk("rst_exec_busy_pre", int'(busy), 1);
    reset_in = 1'b1;
    #1;
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_res", int'(result), 0);
    chk("rst_async_neg", int'(neg), 0);
    #1 reset_in = 1'b0;
    watch_no_done("rst_exec_no_done", 4);
    v = '{2'd0, 20, 22, 42, 0, 0, 1, "post_reset"};
    run_op(v);

`ifdef CALC_DIV_EN
    start = 1'b1; op_code = 2'd3; lhs = 15'd9999; rhs = 15'd7;
    tick();
    start = 1'b0; op_code = 2'd0; lhs = 15'd1; rhs = 15'd1;
    lat = 0;
    do begin
      start = (lat == 5);
      tick();
      lat++;
    end while (!done && lat < 40);
    start = 1'b0;
    chk("div_long_lat", lat, 16);
    chk("div_long_res", int'(result), 1428);
    chk("div_long_err", int'(err), 0);
    tick();
    chk("div_long_idle", int'(busy), 0);
    tick();
    chk("div_no_queue", int'(busy), 0);

    start = 1'b1; op_code = 2'd3; lhs = 15'd9999; rhs = 15'd7;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("div_abort_busy_pre", int'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("div_abort_busy", int'(busy), 0);
    chk("div_abort_res", int'(result), 0);
    watch_no_done("div_abort_no_done", 20);

    start = 1'b1; op_code = 2'd3; lhs = 15'd500; rhs = 15'd9;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset_in = 1'b1;
    #1;
    chk("div_rst_busy", int'(busy), 0);
    #1 reset_in = 1'b0;
    watch_no_done("div_rst_no_done", 20);
    v = '{2'd3, 100, 3, 33, 0, 0, 16, "div_after_rst"};
    run_op(v);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
